// File: rtl/s386_state_scan_reg_if.sv
// Bundles the s386 wrapper's core-side and scan-side signals; master drives core/scan inputs,
// slave is the wrapper itself.
interface s386_state_scan_reg_if #(
  parameter int SW = 6,
  parameter int PW = 7
);
  logic [SW-1:0] ns_in;
  logic [PW-1:0] po_in;
  logic          func_en;
  logic          scan_req;
  logic          scan_si;
  logic [SW-1:0] ps_out;
  logic [PW-1:0] po_q;
  logic          scan_so;
  logic [SW-1:0] scan_unload;
  logic          scan_busy;
  logic          scan_done;

  modport master (
    output ns_in, po_in, func_en, scan_req, scan_si,
    input  ps_out, po_q, scan_so, scan_unload, scan_busy, scan_done
  );

  modport slave (
    input  ns_in, po_in, func_en, scan_req, scan_si,
    output ps_out, po_q, scan_so, scan_unload, scan_busy, scan_done
  );
endinterface

// File: rtl/s386_state_scan_reg.sv
// s386 state/output registers with serial scan; functional capture has 1-cycle latency,
// a scan sequence occupies SW+2 cycles and new requests/enables are dropped while busy.
module s386_state_scan_reg #(
  parameter int            SW        = 6,
  parameter int            PW        = 7,
  parameter logic [SW-1:0] RST_STATE = '0
) (
  input  logic                clk,
  input  logic                rst,
  s386_state_scan_reg_if.slave bus
);

  localparam int CW = (SW > 1) ? $clog2(SW) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    APPLY,
    DONE
  } state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] ps_q, ps_nxt;
  logic [SW-1:0] unl_q, unl_nxt;
  logic [PW-1:0] po_r, po_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ps_q  <= RST_STATE;
      unl_q <= '0;
      po_r  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      ps_q  <= ps_nxt;
      unl_q <= unl_nxt;
      po_r  <= po_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ps_nxt    = ps_q;
    unl_nxt   = unl_q;
    po_nxt    = po_r;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (bus.scan_req) begin
          state_nxt = SHIFT;
          cnt_nxt   = '0;
        end else if (bus.func_en) begin
          ps_nxt = bus.ns_in;
          po_nxt = bus.po_in;
        end
      end
      SHIFT: begin
        // New state enters at the MSB while the old state leaves from the LSB.
        ps_nxt  = {bus.scan_si, ps_q[SW-1:1]};
        unl_nxt = {ps_q[0], unl_q[SW-1:1]};
        if (cnt == CW'(SW - 1)) begin
          state_nxt = APPLY;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      APPLY: begin
        ps_nxt    = bus.ns_in;
        po_nxt    = bus.po_in;
        state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.ps_out      = ps_q;
  assign bus.po_q        = po_r;
  assign bus.scan_so     = ps_q[0];
  assign bus.scan_unload = unl_q;
  assign bus.scan_busy   = (state != IDLE);
  assign bus.scan_done   = (state == DONE);

endmodule

// File: tb/tb_s386_state_scan_reg.sv
// Randomized and directed stimulus for s386_state_scan_reg; expected outputs from a
// sequence-level model are queued and checked by an independent monitor.
module tb_s386_state_scan_reg;

  localparam int SW = 6;
  localparam int PW = 7;
  localparam int SMASK = (1 << SW) - 1;
  localparam int PMASK = (1 << PW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  s386_state_scan_reg_if #(.SW(SW), .PW(PW)) bus ();

  s386_state_scan_reg #(
    .SW(SW),
    .PW(PW),
    .RST_STATE('0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    int ps;
    int po;
    int unl;
    int busy;
    int done;
    int so;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Model: k < 0 is idle; 0..SW-1 is shifts completed; SW is the apply cycle; SW+1 is done.
  int m_ps, m_po, m_unl;
  int m_k = -1;
  int m_old_ps, m_old_unl, m_col;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit fe, input bit rq, input bit si,
                      input int ns, input int po);
    exp_t e;
    @(negedge clk);
    rst          = r;
    bus.func_en  = fe;
    bus.scan_req = rq;
    bus.scan_si  = si;
    bus.ns_in    = ns[SW-1:0];
    bus.po_in    = po[PW-1:0];
    if (r) begin
      m_ps  = 0;
      m_po  = 0;
      m_unl = 0;
      m_k   = -1;
    end else if (m_k < 0) begin
      if (rq) begin
        m_k       = 0;
        m_old_ps  = m_ps;
        m_old_unl = m_unl;
        m_col     = 0;
      end else if (fe) begin
        m_ps = ns & SMASK;
        m_po = po & PMASK;
      end
    end else if (m_k < SW) begin
      m_col = m_col | (int'(si) << m_k);
      m_k++;
      m_ps  = ((m_old_ps >> m_k) | (m_col << (SW - m_k))) & SMASK;
      m_unl = ((m_old_unl >> m_k) | ((m_old_ps & ((1 << m_k) - 1)) << (SW - m_k))) & SMASK;
    end else if (m_k == SW) begin
      m_ps = ns & SMASK;
      m_po = po & PMASK;
      m_k  = SW + 1;
    end else begin
      m_k = -1;
    end
    e.ps   = m_ps;
    e.po   = m_po;
    e.unl  = m_unl;
    e.busy = (m_k >= 0) ? 1 : 0;
    e.done = (m_k == SW + 1) ? 1 : 0;
    e.so   = m_ps & 1;
    sb.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic scan_seq(input int pat, input int ns, input int po, input bit junk);
    step(0, 1'($urandom_range(0, 1)), 1, 0, int'($urandom), int'($urandom));
    for (int i = 0; i < SW; i++)
      step(0, 1, junk && (i == 2), 1'((pat >> i) & 1), int'($urandom), int'($urandom));
    step(0, 1'($urandom_range(0, 1)), 0, 0, ns, po);
    step(0, 1, junk, 0, int'($urandom), int'($urandom));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("ps_out", 32'(bus.ps_out), e.ps);
        chk("po_q", 32'(bus.po_q), e.po);
        chk("scan_unload", 32'(bus.scan_unload), e.unl);
        chk("scan_busy", 32'(bus.scan_busy), e.busy);
        chk("scan_done", 32'(bus.scan_done), e.done);
        chk("scan_so", 32'(bus.scan_so), e.so);
      end
    end
  end

  initial begin : driver
    int si_pat;
    rst          = 1'b1;
    bus.func_en  = 1'b0;
    bus.scan_req = 1'b0;
    bus.scan_si  = 1'b0;
    bus.ns_in    = '0;
    bus.po_in    = '0;

    step(1, 1, 0, 1, 'h3F, 'h7F);
    settle();
    chk("rst_ps", 32'(bus.ps_out), 0);
    chk("rst_busy", 32'(bus.scan_busy), 0);

    step(0, 1, 0, 0, 'h2D, 'h55);
    settle();
    chk("func_ps", 32'(bus.ps_out), 'h2D);
    chk("func_po", 32'(bus.po_q), 'h55);
    step(0, 0, 0, 0, 'h12, 'h33);
    settle();
    chk("hold_ps", 32'(bus.ps_out), 'h2D);
    chk("hold_po", 32'(bus.po_q), 'h55);

    // Full scan loading 010011 (si = 1,1,0,0,1,0), then capture 2A / 0F.
    si_pat = 'b010011;
    step(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < SW; i++)
      step(0, 1, 0, 1'((si_pat >> i) & 1), int'($urandom), int'($urandom));
    settle();
    chk("scan_ps", 32'(bus.ps_out), 'h13);
    chk("scan_unl", 32'(bus.scan_unload), 'h2D);
    step(0, 0, 0, 0, 'h2A, 'h0F);
    settle();
    chk("apply_ps", 32'(bus.ps_out), 'h2A);
    chk("apply_po", 32'(bus.po_q), 'h0F);
    chk("apply_done", 32'(bus.scan_done), 1);
    step(0, 0, 0, 0, 0, 0);

    // Back-to-back request right after DONE; unload must hold the first APPLY result.
    scan_seq(int'($urandom), 'h15, 'h22, 0);
    settle();
    chk("b2b_unl", 32'(bus.scan_unload), 'h2A);

    // Extra requests during SHIFT and DONE must not start another sequence.
    scan_seq(int'($urandom), 'h07, 'h11, 1);
    step(0, 0, 0, 0, 0, 0);
    settle();
    chk("junk_busy", 32'(bus.scan_busy), 0);

    // Reset after the third shift aborts without a done pulse.
    step(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    settle();
    chk("abort_ps", 32'(bus.ps_out), 0);
    chk("abort_unl", 32'(bus.scan_unload), 0);
    chk("abort_busy", 32'(bus.scan_busy), 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, int'($urandom), int'($urandom));

    // scan_req beats func_en; rst beats scan_req.
    step(0, 1, 1, 0, 'h3F, 'h7F);
    settle();
    chk("reqfe_busy", 32'(bus.scan_busy), 1);
    chk("reqfe_ps", 32'(bus.ps_out), 0);
    step(1, 0, 1, 0, 0, 0);
    settle();
    chk("reqrst_busy", 32'(bus.scan_busy), 0);
    step(0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
           int'($urandom), int'($urandom));
    end

    repeat (2) @(posedge clk);
    #3;
    chk("sb_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/s386_state_scan_reg.md
Name: s386_state_scan_reg

Overview:
- Sequential wrapper for the combinational s386 next-state/output core.
- Holds the 6 present-state flops that drive core inputs v12..v7 and captures the core's next-state bits (v13_D_12..v13_D_7).
- Registers the 7 primary outputs (v13_D_6, n29, n34, n39, n44, n49, n54).
- Provides a serial scan load/unload sequence with a busy/done handshake, used for test and fault-injection runs.

Parameters:
- SW, 6, state-register width (core state bits v12..v7; bit 5 = v12, bit 0 = v7)
- PW, 7, primary-output width (bit 6 = v13_D_6, bits 5..0 = n29, n34, n39, n44, n49, n54)
- RST_STATE, 6'b000000, state-register value loaded on reset

Ports:
- clk  in  1  single clock; all flops rising-edge
- rst  in  1  synchronous, active-high reset
- ns_in  in  SW  next-state from core (v13_D_12..v13_D_7)
- po_in  in  PW  primary outputs from core
- func_en  in  1  functional-mode clock enable
- scan_req  in  1  one-cycle request to start a scan sequence
- scan_si  in  1  serial scan data in
- ps_out  out  SW  present state to core (v12..v7)
- po_q  out  PW  registered primary outputs
- scan_so  out  1  serial scan data out; always equals ps_out[0]
- scan_unload  out  SW  state shifted out by the most recent scan sequence
- scan_busy  out  1  high when FSM is not in IDLE
- scan_done  out  1  one-cycle pulse at end of sequence

Behaviour:
- Reset (rst=1 at a clk edge):
  - ps_out=RST_STATE, po_q=0, scan_unload=0, cnt=0, FSM=IDLE.
  - scan_busy=0 and scan_done=0 from the next cycle.
  - rst overrides every other input, including scan_req in the same cycle.
- FSM states: IDLE, SHIFT, APPLY, DONE.
- IDLE:
  - If scan_req=1: go to SHIFT and clear cnt. ps_out and po_q hold; scan_req has priority over func_en.
  - Else if func_en=1: ps_out<=ns_in and po_q<=po_in. One-cycle latency.
  - Else: all registers hold.
- SHIFT, each cycle:
  - ps_out<={scan_si, ps_out[SW-1:1]}, so state is loaded LSB-first.
  - scan_unload<={ps_out[0], scan_unload[SW-1:1]}.
  - cnt increments.
  - When cnt==SW-1, go to APPLY.
  - Exactly SW shift cycles occur. po_q holds.
- APPLY, exactly one cycle:
  - ps_out<=ns_in and po_q<=po_in. This is a functional capture from the scanned-in state; func_en is ignored.
  - Go to DONE.
- DONE:
  - scan_done=1 for this cycle only; registers hold.
  - Go to IDLE.
- Sequence timing, with scan_req sampled at edge E:
  - scan_busy is high for SW+2 cycles, from after E through the DONE cycle.
  - scan_done is high in the cycle after edge E+SW+1.
  - scan_busy is low again after edge E+SW+2.
- While scan_busy=1:
  - scan_req is ignored and not queued.
  - func_en is ignored.
- scan_req asserted during the DONE cycle is ignored. A new request is accepted only in IDLE.
- rst during SHIFT, APPLY or DONE:
  - Aborts to IDLE with the reset values above.
  - scan_done is not asserted for the aborted sequence.
- scan_unload holds its value between sequences; it is cleared only by rst.
- scan_done and scan_busy are registered-state decodes: no combinational path from inputs.
- scan_so is combinational from ps_out[0] only.
- cnt is ceil(log2(SW)) bits and never wraps, because SHIFT exits at SW-1.

Test Plan:
- Reset then functional step: rst 1 cycle; func_en=1, ns_in=6'b101101, po_in=7'h55 -> after 1 edge ps_out=101101, po_q=7'h55. Then func_en=0 with ns_in changed -> ps_out and po_q hold.
- Full scan: ps_out=101101; scan_req pulse; scan_si drives 1,1,0,0,1,0 (LSB-first of 010011); ns_in=6'h2A and po_in=7'h0F during APPLY -> after 6 shifts ps_out=010011 and scan_unload=101101; after APPLY ps_out=101010 and po_q=7'h0F; scan_done high exactly one cycle; scan_busy high for exactly 8 cycles.
- scan_so tracking: during the above sequence, scan_so emits 1,0,1,1,0,1 on successive shift cycles (old state LSB-first).
- Reset mid-scan: assert rst after the 3rd shift cycle -> ps_out=000000, scan_unload=0, scan_busy=0 next cycle; no scan_done pulse in the following 10 cycles.
- Request/enable collisions:
  - scan_req pulsed again during SHIFT and during DONE -> no second sequence (busy drops after 8 cycles).
  - scan_req and func_en both high in IDLE -> SHIFT entered and ps_out not loaded from ns_in.
  - scan_req and rst both high -> stays IDLE with reset values.
- Back-to-back: scan_req pulsed in the first IDLE cycle after DONE -> second sequence starts; scan_unload equals the state produced by the first APPLY.
